qspi_arb: RTL and testbench
===========================

Name: qspi_arb

Overview:
- Arbiter and sequencer in front of the qspi serial memory controller.
- Shares one qspi engine between the instruction-cache line-fill requester and the data-cache fill/writeback requester.
- Latches the winner's command and holds it stable for the whole serial transaction.
- Tracks transaction boundaries from the qspi chip-selects; returns a done pulse to the owner.

Parameters:
- PA, 24, physical address width in bits.
- LINE_LENGTH, 4, cache line length in bytes; LB = $clog2(LINE_LENGTH) low address bits are not carried.
- MEM_BIT, PA-1, address bit that selects the device (q_mem); 0 = cs[0] device, 1 = cs[1] device.
- GAP_CYCLES, 2, minimum idle cycles between the end of one transaction and the next q_req (range 1..15).
- AGE_LIMIT, 4, consecutive data grants before the instruction side is forced (QSPI_ARB_AGE_EN only).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction line-fill request, level, held until i_ack.
- i_addr  in  PA-LB  instruction line address [PA-1:LB].
- i_ack  out  1  one-cycle grant pulse; requester may change i_addr after it.
- i_done  out  1  one-cycle pulse when the instruction transaction's chip-select has released.
- d_req  in  1  data request, level, held until d_ack.
- d_write  in  1  1 = line writeback, 0 = line fill.
- d_addr  in  PA-LB  data line address.
- d_ack  out  1  grant pulse for the data side.
- d_done  out  1  completion pulse for the data side.
- q_req  out  1  one-cycle start to the qspi engine.
- q_i_d  out  1  1 = instruction transaction (routes read strobes to the icache).
- q_mem  out  1  device select = latched addr[MEM_BIT].
- q_write  out  1  write transaction.
- q_paddr  out  PA-LB  latched line address.
- q_cs  in  2  qspi chip-select outputs (active low) used as the busy indication.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): state=INIT; all outputs 0; latches 0; age counter 0.
- INIT: waits for q_cs != 2'b11, then q_cs == 2'b11. This covers the qspi power-on quad-enable command. Then goes to GAP.
- IDLE:
  - No request → stay.
  - Select winner: d_req wins if both requesters are active (see aging).
  - Latch id, write, addr; assert the winner's ack this cycle; next state ISSUE.
- ISSUE: q_req=1 for exactly one cycle; next state WAIT_START.
- WAIT_START: wait for q_cs != 2'b11, then go to WAIT_END.
- WAIT_END:
  - Wait for q_cs == 2'b11.
  - Then pulse the owner's done (i_done if latched id=1, else d_done) in that cycle.
  - Load the gap counter with GAP_CYCLES-1; next state GAP.
- GAP: count down to 0, then go to IDLE.
- Latency: request in IDLE at cycle N → ack at N, q_req at N+1.
- q_i_d/q_mem/q_write/q_paddr are driven from the latches continuously and change only in the IDLE grant cycle. They are therefore stable from q_req through release.
- d_write=1 with q_mem=0 (flash) is forwarded unchanged; write protection is not this block's job.
- Requests arriving outside IDLE are held by the requester; no queueing.
- Only one ack per transaction; exactly one done per ack.
- Reset mid-transaction: immediate return to INIT; no done is issued. Requesters are reset on the same net.

Optional Feature:
- Macro QSPI_ARB_AGE_EN.
- Defined:
  - 3-bit counter increments on each data grant made while i_req=1.
  - Counter clears on any instruction grant.
  - When counter == AGE_LIMIT and i_req=1, the instruction side wins over d_req.
- Undefined: strict data priority; counter and AGE_LIMIT logic absent.

Decomposition:
- Package qspi_arb_pkg: state enum (INIT, IDLE, ISSUE, WAIT_START, WAIT_END, GAP), 2'b11 CS_IDLE constant.
- No sub-module; the optional age counter stays inline.

Test Plan:
- Reset, then q_cs driven 11→10 (5 cycles)→11 → exactly GAP_CYCLES cycles later busy=0; no q_req before that.
- i_req with i_addr=22'h012345 alone → i_ack same cycle, q_req next cycle with q_i_d=1, q_write=0, q_mem=0, q_paddr=22'h012345. Then q_cs=10 for 20 cycles then 11 → i_done single pulse.
- i_req and d_req (d_write=1, addr MSB=1) in the same cycle → d_ack first with q_mem=1, q_write=1. i_ack only after d_done plus GAP_CYCLES.
- d_addr changed right after d_ack during WAIT_END → q_paddr unchanged until the next grant.
- With QSPI_ARB_AGE_EN, both requesters held permanently → grant pattern D,D,D,D,I repeating. Without the macro → only D grants.
- reset_n asserted in WAIT_END → outputs 0 asynchronously; no d_done; after release, INIT is re-entered.

Source files
------------

// File: rtl/qspi_arb_pkg.sv
// qspi_arb_pkg: shared state encoding and chip-select idle constant for qspi_arb.
package qspi_arb_pkg;
  typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT_START, WAIT_END, GAP} state_t;
  localparam logic [1:0] CS_IDLE = 2'b11;
endpackage

// File: rtl/qspi_arb_if.sv
// qspi_arb_if: requester-side and qspi-engine-side signals of qspi_arb.
interface qspi_arb_if #(parameter int PA = 24, parameter int LINE_LENGTH = 4);
  localparam int AW = PA - $clog2(LINE_LENGTH);
  logic i_req, i_ack, i_done;
  logic [AW-1:0] i_addr;
  logic d_req, d_write, d_ack, d_done;
  logic [AW-1:0] d_addr;
  logic q_req, q_i_d, q_mem, q_write;
  logic [AW-1:0] q_paddr;
  logic [1:0] q_cs;
  logic busy;
  modport slave(
    input i_req, i_addr, d_req, d_write, d_addr, q_cs,
    output i_ack, i_done, d_ack, d_done, q_req, q_i_d, q_mem, q_write, q_paddr, busy
  );
  modport master(
    output i_req, i_addr, d_req, d_write, d_addr, q_cs,
    input i_ack, i_done, d_ack, d_done, q_req, q_i_d, q_mem, q_write, q_paddr, busy
  );
endinterface

// File: rtl/qspi_arb.sv
// qspi_arb: shares one qspi engine between icache and dcache fills/writebacks.
// Define QSPI_ARB_AGE_EN to let a starved instruction side win after AGE_LIMIT data grants.
module qspi_arb
  import qspi_arb_pkg::*;
#(
  parameter int PA = 24,
  parameter int LINE_LENGTH = 4,
  parameter int MEM_BIT = PA - 1,
  parameter int GAP_CYCLES = 2
`ifdef QSPI_ARB_AGE_EN
  , parameter int AGE_LIMIT = 4
`endif
) (
  input logic clk,
  input logic reset_n,
  qspi_arb_if.slave bus
);
  localparam int LB = $clog2(LINE_LENGTH);
  state_t state;
  logic [3:0] gap;
  logic seen, id_q, wr_q, grant_i, grant_d, cs_idle, done_now;
  logic [PA-LB-1:0] addr_q;
  assign cs_idle = bus.q_cs == CS_IDLE;
`ifdef QSPI_ARB_AGE_EN
  logic [2:0] age;
  assign grant_i = bus.i_req && (!bus.d_req || age == 3'(AGE_LIMIT));
`else
  assign grant_i = bus.i_req && !bus.d_req;
`endif
  assign grant_d = bus.d_req && !grant_i;
  assign bus.i_ack = state == IDLE && grant_i;
  assign bus.d_ack = state == IDLE && grant_d;
  assign done_now = state == WAIT_END && cs_idle;
  assign bus.i_done = done_now && id_q;
  assign bus.d_done = done_now && !id_q;
  assign bus.q_i_d = id_q;
  assign bus.q_write = wr_q;
  assign bus.q_paddr = addr_q;
  assign bus.q_mem = addr_q[MEM_BIT-LB];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      gap <= '0;
      seen <= 1'b0;
      id_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      bus.q_req <= 1'b0;
      bus.busy <= 1'b0;
`ifdef QSPI_ARB_AGE_EN
      age <= '0;
`endif
    end else begin
      bus.q_req <= 1'b0;
      bus.busy <= 1'b1;
      case (state)
        INIT: begin
          // Wait out the power-on quad-enable command the engine issues itself
          if (!cs_idle) seen <= 1'b1;
          else if (seen) begin
            gap <= 4'(GAP_CYCLES - 1);
            state <= GAP;
          end
        end
        IDLE: begin
          if (grant_i || grant_d) begin
            id_q <= grant_i;
            wr_q <= grant_d && bus.d_write;
            addr_q <= grant_i ? bus.i_addr : bus.d_addr;
            bus.q_req <= 1'b1;
            state <= ISSUE;
          end else bus.busy <= 1'b0;
        end
        ISSUE: state <= WAIT_START;
        WAIT_START: if (!cs_idle) state <= WAIT_END;
        WAIT_END: begin
          if (cs_idle) begin
            gap <= 4'(GAP_CYCLES - 1);
            state <= GAP;
          end
        end
        GAP: begin
          if (gap == 4'd0) begin
            state <= IDLE;
            bus.busy <= 1'b0;
          end else gap <= gap - 4'd1;
        end
        default: state <= INIT;
      endcase
`ifdef QSPI_ARB_AGE_EN
      if (state == IDLE && grant_i) age <= '0;
      else if (state == IDLE && grant_d && bus.i_req) age <= age + 3'd1;
`endif
    end
  end
endmodule

// File: tb/tb_qspi_arb.sv
// tb_qspi_arb: directed stimulus with a cycle-level reference model checked every cycle.
module tb_qspi_arb;
  localparam int GAP = 2;
  localparam int AGE_LIMIT = 4;
`ifdef QSPI_ARB_AGE_EN
  localparam bit AGE_ON = 1'b1;
  localparam string AGE_PATTERN = "DDDDIDDDDI";
`else
  localparam bit AGE_ON = 1'b0;
  localparam string AGE_PATTERN = "DDDDDDDDDD";
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  int n_chk = 0, n_fail = 0;
  qspi_arb_if bus();
  qspi_arb dut(.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: cycle numbers since reset release drive every expectation
  int c, free_at, g, streak;
  bit booted, seen, txn, started;
  bit exp_id, exp_wr;
  logic [21:0] exp_addr;
  string glog;

  task automatic mdl_reset();
    c = 0; free_at = 0; g = 0; streak = 0;
    booted = 0; seen = 0; txn = 0; started = 0;
    exp_id = 0; exp_wr = 0; exp_addr = '0;
  endtask

  always @(negedge clk) begin
    bit idle, wi, wd, done;
    if (!reset_n) mdl_reset();
    else begin
      idle = booted && !txn && c >= free_at;
      wi = idle && bus.i_req && (!bus.d_req || (AGE_ON && streak == AGE_LIMIT));
      wd = idle && bus.d_req && !wi;
      done = txn && started && bus.q_cs == 2'b11;
      check("i_ack", bus.i_ack, wi);
      check("d_ack", bus.d_ack, wd);
      check("q_req", bus.q_req, txn && c == g + 1);
      check("busy", bus.busy, c != 0 && !idle);
      check("i_done", bus.i_done, done && exp_id);
      check("d_done", bus.d_done, done && !exp_id);
      check("q_i_d", bus.q_i_d, exp_id);
      check("q_write", bus.q_write, exp_wr);
      check("q_mem", bus.q_mem, exp_addr[21]);
      check("q_paddr", bus.q_paddr, exp_addr);
      if (!booted) begin
        if (bus.q_cs != 2'b11) seen = 1;
        else if (seen) begin
          booted = 1;
          free_at = c + GAP + 1;
        end
      end
      if (done) begin
        txn = 0;
        free_at = c + GAP + 1;
      end
      if (txn && !started && c >= g + 2 && bus.q_cs != 2'b11) started = 1;
      if (wi || wd) begin
        txn = 1; g = c; started = 0;
        exp_id = wi;
        exp_wr = wd && bus.d_write;
        exp_addr = wi ? bus.i_addr : bus.d_addr;
        streak = wi ? 0 : (bus.i_req ? streak + 1 : streak);
        glog = {glog, wi ? "I" : "D"};
      end
      c++;
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 40 && bus.busy; k++) cyc(1);
    check("reach_idle", bus.busy, 0);
  endtask

  task automatic wait_qreq();
    for (int k = 0; k < 40 && !bus.q_req; k++) cyc(1);
    check("reach_q_req", bus.q_req, 1);
  endtask

  initial begin
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_write = 0; bus.d_addr = '0;
    bus.q_cs = 2'b11;
    cyc(3);
    check("rst_busy", bus.busy, 0);
    check("rst_q_req", bus.q_req, 0);
    reset_n = 1;
    // Boot: power-on command on cs[0], then GAP cycles before IDLE
    cyc(1); bus.q_cs = 2'b10;
    cyc(5); bus.q_cs = 2'b11;
    cyc(2); check("boot_busy_gap", bus.busy, 1);
    cyc(1); check("boot_busy_idle", bus.busy, 0);
    // Lone instruction fill
    bus.i_addr = 22'h012345; bus.i_req = 1; #1;
    check("i_ack_lit", bus.i_ack, 1);
    cyc(1); bus.i_req = 0; #1;
    check("q_req_lit", bus.q_req, 1);
    check("q_i_d_lit", bus.q_i_d, 1);
    check("q_paddr_lit", bus.q_paddr, 22'h012345);
    cyc(1); bus.q_cs = 2'b10;
    cyc(20); bus.q_cs = 2'b11; #1;
    check("i_done_lit", bus.i_done, 1);
    cyc(1); check("i_done_single", bus.i_done, 0);
    wait_idle();
    // Simultaneous requests: data first, instruction waits out the gap
    bus.i_addr = 22'h000100; bus.d_addr = 22'h2ABCDE; bus.d_write = 1;
    bus.i_req = 1; bus.d_req = 1; #1;
    check("both_d_ack", bus.d_ack, 1);
    check("both_i_ack", bus.i_ack, 0);
    cyc(1); bus.d_req = 0; #1;
    check("d_q_mem", bus.q_mem, 1);
    check("d_q_write", bus.q_write, 1);
    check("d_q_paddr", bus.q_paddr, 22'h2ABCDE);
    cyc(1); bus.q_cs = 2'b01;
    cyc(1); bus.d_addr = 22'h155555;
    cyc(3); check("paddr_hold", bus.q_paddr, 22'h2ABCDE);
    bus.q_cs = 2'b11; #1;
    check("d_done_lit", bus.d_done, 1);
    check("i_wait0", bus.i_ack, 0);
    cyc(1); check("i_wait1", bus.i_ack, 0);
    cyc(1); check("i_wait2", bus.i_ack, 0);
    cyc(1); check("i_ack_after_gap", bus.i_ack, 1);
    cyc(1); bus.i_req = 0; #1;
    check("i_paddr", bus.q_paddr, 22'h000100);
    check("i_write", bus.q_write, 0);
    cyc(1); bus.q_cs = 2'b10;
    cyc(2); bus.q_cs = 2'b11;
    cyc(1); wait_idle();
    // Both sides held permanently
    glog = "";
    bus.d_write = 0; bus.i_req = 1; bus.d_req = 1;
    for (int t = 0; t < 10; t++) begin
      wait_qreq();
      if (t == 9) begin bus.i_req = 0; bus.d_req = 0; end
      cyc(1); bus.q_cs = 2'b10;
      cyc(2); bus.q_cs = 2'b11;
      cyc(1);
    end
    wait_idle();
    n_chk++;
    if (glog != AGE_PATTERN) begin
      n_fail++;
      $display("FAIL grant_pattern: got %s expected %s", glog, AGE_PATTERN);
    end
    // Reset in the middle of a data transaction
    bus.d_addr = 22'h0000AA; bus.d_req = 1;
    cyc(1); bus.d_req = 0;
    cyc(1); bus.q_cs = 2'b10;
    cyc(2); reset_n = 0; #1;
    check("arst_busy", bus.busy, 0);
    check("arst_paddr", bus.q_paddr, 0);
    check("arst_q_mem", bus.q_mem, 0);
    bus.q_cs = 2'b11; #1;
    check("arst_no_done", bus.d_done, 0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1;
    cyc(3);
    check("reinit_busy", bus.busy, 1);
    check("reinit_q_req", bus.q_req, 0);
    cyc(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
